// File: rtl/fp11_pkg.sv
// fp11 format constants, FSM state type and pack/unpack helpers shared by
// the accumulator and its add core.
package fp11_pkg;

  localparam int unsigned SIGN_BIT = 10;
  localparam int unsigned EXP_W    = 6;
  localparam int unsigned MAN_W    = 4;
  localparam int unsigned SIG_W    = 8;   // hidden 1 + mantissa + 3 guard bits

  localparam int unsigned EXP_BIAS = 31;
  localparam int unsigned EXP_MAX  = 63;

  localparam logic [10:0] FP11_ZERO    = 11'h000;
  localparam logic [9:0]  FP11_MAX_MAG = 10'h3FF;

  typedef enum logic [1:0] {
    S_ACC,
    S_ALIGN,
    S_ADD,
    S_OUT
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp11_unp_t;

  // Operands after alignment; A is the larger magnitude, B already shifted.
  typedef struct packed {
    logic             sign_a;
    logic             sign_b;
    logic [EXP_W-1:0] exp_a;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;
  } fp11_align_t;

  // A zero exponent field means zero regardless of the mantissa bits.
  function automatic fp11_unp_t fp11_unpack(input logic [10:0] w);
    fp11_unp_t u;
    u.sign = w[SIGN_BIT];
    u.exp  = w[9:4];
    u.sig  = (w[9:4] == '0) ? '0 : {1'b1, w[3:0], 3'b000};
    return u;
  endfunction

  // Guard bits are simply dropped (truncation rounding).
  function automatic logic [10:0] fp11_pack(input logic             sign,
                                            input logic [EXP_W-1:0] exp,
                                            input logic [SIG_W-1:0] sig);
    return {sign, exp, sig[6:3]};
  endfunction

endpackage

// File: rtl/fp11_accum_if.sv
// Term input and group-result output handshakes of the fp11 accumulator.
interface fp11_accum_if;
  logic [10:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_ovf;
  logic        out_unf;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ovf, out_unf
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ovf, out_unf
  );
endinterface

// File: rtl/fp11_add_core.sv
// Combinational fp11 adder split in two halves: align (swap + shift) and
// add/normalize/pack. The caller registers the align result in between.
module fp11_add_core
  import fp11_pkg::*;
(
  input  logic [10:0] i_acc,
  input  logic [10:0] i_term,
  output fp11_align_t o_align,
  input  fp11_align_t i_align,
  output logic [10:0] o_sum,
  output logic        o_ovf,
  output logic        o_unf
);

  fp11_unp_t          w_acc_u;
  fp11_unp_t          w_term_u;
  fp11_unp_t          w_big;
  fp11_unp_t          w_small;
  logic [9:0]         w_key_acc;
  logic [9:0]         w_key_term;
  logic [EXP_W-1:0]   w_diff;
  logic [SIG_W:0]     w_sum9;
  logic [3:0]         w_lz;
  logic               w_found;
  logic [SIG_W-1:0]   w_norm;
  logic signed [7:0]  w_exp;

  // Align: order operands by magnitude and shift the smaller one right.
  always_comb begin
    w_acc_u    = fp11_unpack(i_acc);
    w_term_u   = fp11_unpack(i_term);
    w_key_acc  = (w_acc_u.sig  == '0) ? '0 : i_acc[9:0];
    w_key_term = (w_term_u.sig == '0) ? '0 : i_term[9:0];
    if (w_key_term > w_key_acc) begin
      w_big   = w_term_u;
      w_small = w_acc_u;
    end else begin
      w_big   = w_acc_u;
      w_small = w_term_u;
    end
    w_diff         = w_big.exp - w_small.exp;
    o_align.sign_a = w_big.sign;
    o_align.sign_b = w_small.sign;
    o_align.exp_a  = w_big.exp;
    o_align.sig_a  = w_big.sig;
    o_align.sig_b  = (w_diff >= 6'd8) ? '0 : (w_small.sig >> w_diff);
  end

  // Add/subtract, normalize, then saturate or flush on exponent range.
  always_comb begin
    o_sum   = FP11_ZERO;
    o_ovf   = 1'b0;
    o_unf   = 1'b0;
    w_lz    = '0;
    w_found = 1'b0;
    w_norm  = '0;
    w_exp   = '0;
    if (i_align.sign_a == i_align.sign_b)
      w_sum9 = {1'b0, i_align.sig_a} + {1'b0, i_align.sig_b};
    else
      w_sum9 = {1'b0, i_align.sig_a} - {1'b0, i_align.sig_b};

    for (int unsigned i = 0; i < 8; i++) begin
      if (!w_found) begin
        if (w_sum9[3'(7 - i)]) w_found = 1'b1;
        else                   w_lz    = w_lz + 4'd1;
      end
    end

    if (w_sum9[8]) begin
      w_norm = w_sum9[8:1];
      w_exp  = $signed({2'b00, i_align.exp_a}) + 8'sd1;
    end else begin
      w_norm = w_sum9[7:0] << w_lz;
      w_exp  = $signed({2'b00, i_align.exp_a}) - $signed({4'b0000, w_lz});
    end

    if (w_sum9 == '0) begin
      o_sum = FP11_ZERO;
    end else if (w_exp > 8'sd63) begin
      o_sum = {i_align.sign_a, FP11_MAX_MAG};
      o_ovf = 1'b1;
    end else if (w_exp < 8'sd1) begin
      o_sum = FP11_ZERO;
      o_unf = 1'b1;
    end else begin
      o_sum = fp11_pack(i_align.sign_a, w_exp[5:0], w_norm);
    end
  end

endmodule

// File: rtl/fp11_accum.sv
// Accumulates LEN fp11 terms per group into one fp11 sum with sticky
// overflow/underflow flags; one term per three cycles.
module fp11_accum
  import fp11_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fp11_accum_if.slave  bus
);

  state_t             r_state;
  logic [10:0]        r_term;
  logic [10:0]        r_acc;
  fp11_align_t        r_align;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_unf;
  logic               r_in_ready;
  logic               r_out_valid;

  fp11_align_t        w_align;
  logic [10:0]        w_sum;
  logic               w_ovf;
  logic               w_unf;

  fp11_add_core u_add (
    .i_acc   (r_acc),
    .i_term  (r_term),
    .o_align (w_align),
    .i_align (r_align),
    .o_sum   (w_sum),
    .o_ovf   (w_ovf),
    .o_unf   (w_unf)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_unf   = r_unf;

  // Group FSM: accept term, align, add, and present the result per group.
  // in_ready comes up one cycle after reset since it is a registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACC;
      r_term      <= FP11_ZERO;
      r_acc       <= FP11_ZERO;
      r_align     <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (r_in_ready && bus.in_valid) begin
            r_term     <= bus.in_data;
            r_in_ready <= 1'b0;
            r_state    <= S_ALIGN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_ALIGN: begin
          r_align <= w_align;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_acc <= w_sum;
          r_ovf <= r_ovf | w_ovf;
          r_unf <= r_unf | w_unf;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(LEN - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_ACC;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_acc       <= FP11_ZERO;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fp11_accum.sv
// Directed bench for fp11_accum with LEN=4: group sums, flags, latency,
// backpressure and asynchronous reset.
module tb_fp11_accum;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fp11_accum_if bus ();

  fp11_accum #(
    .LEN   (4),
    .CNT_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one term and return #1 after the accepting clock edge.
  task automatic send(input logic [10:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 11'h7FF;
  endtask

  // Latency counted from the handshake cycle (t) to first out_valid cycle.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
  endtask

  task automatic finish_group(input string tag, input logic [10:0] exp_d,
                              input logic exp_ovf, input logic exp_unf);
    int lat;
    wait_out(lat);
    check({tag, "_lat"},  lat, 32'd3);
    check({tag, "_data"}, {21'd0, bus.out_data}, {21'd0, exp_d});
    check({tag, "_ovf"},  {31'd0, bus.out_ovf}, {31'd0, exp_ovf});
    check({tag, "_unf"},  {31'd0, bus.out_unf}, {31'd0, exp_unf});
    @(negedge clk);
    check({tag, "_vld_clr"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_acc_clr"}, {21'd0, bus.out_data}, 32'd0);
  endtask

  task automatic run_group(input string tag,
                           input logic [10:0] t0, input logic [10:0] t1,
                           input logic [10:0] t2, input logic [10:0] t3,
                           input logic [10:0] exp_d,
                           input logic exp_ovf, input logic exp_unf);
    send(t0);
    send(t1);
    send(t2);
    send(t3);
    finish_group(tag, exp_d, exp_ovf, exp_unf);
  endtask

  initial begin
    int lat;
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    #1;
    check("rst_data",  {21'd0, bus.out_data}, 32'd0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_ovf",   {31'd0, bus.out_ovf}, 32'd0);
    check("rst_unf",   {31'd0, bus.out_unf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1+1+1+1 = 4.0, with per-term ready spacing checked on the first term
    send(11'h1F0);
    @(negedge clk);
    check("g1_rdy_t1", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("g1_rdy_t2", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("g1_rdy_t3", {31'd0, bus.in_ready}, 32'd1);
    check("g1_part",   {21'd0, bus.out_data}, 32'h1F0);
    send(11'h1F0);
    send(11'h1F0);
    send(11'h1F0);
    finish_group("g1", 11'h210, 1'b0, 1'b0);

    // 1.5+1.5+1+1 = 5.0
    run_group("g2", 11'h1F8, 11'h1F8, 11'h1F0, 11'h1F0, 11'h214, 1'b0, 1'b0);

    // 1-1+2+0 = 2.0, exact cancellation leaves +0 after the second term
    send(11'h1F0);
    send(11'h5F0);
    repeat (3) @(negedge clk);
    check("g3_cancel", {21'd0, bus.out_data}, 32'h000);
    check("g3_rdy",    {31'd0, bus.in_ready}, 32'd1);
    send(11'h200);
    send(11'h000);
    finish_group("g3", 11'h200, 1'b0, 1'b0);

    // exponent difference 11: small terms vanish entirely
    run_group("g4", 11'h1F0, 11'h140, 11'h140, 11'h140, 11'h1F0, 1'b0, 1'b0);

    // saturation, then flags must not leak into the next group
    run_group("g5", 11'h3FF, 11'h3FF, 11'h3FF, 11'h3FF, 11'h3FF, 1'b1, 1'b0);
    run_group("g6", 11'h1F0, 11'h1F0, 11'h1F0, 11'h1F0, 11'h210, 1'b0, 1'b0);

    // 1.5-1.0 = 0.5 needs a one-bit left normalization
    run_group("g7", 11'h1F8, 11'h5F0, 11'h000, 11'h000, 11'h1E0, 1'b0, 1'b0);

    // result exponent drops to 0: flush to +0 with sticky underflow
    run_group("g8", 11'h018, 11'h410, 11'h000, 11'h000, 11'h000, 1'b0, 1'b1);

    // backpressure: result held, offered terms refused
    bus.out_ready = 1'b0;
    send(11'h1F0);
    send(11'h1F0);
    send(11'h1F0);
    send(11'h1F0);
    wait_out(lat);
    check("bp_lat", lat, 32'd3);
    bus.in_data  = 11'h3FF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data",  {21'd0, bus.out_data}, 32'h210);
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_vld", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_acc", {21'd0, bus.out_data}, 32'h000);

    // reset after two terms discards the partial sum
    send(11'h1F0);
    send(11'h1F0);
    repeat (3) @(negedge clk);
    check("rs_part", {21'd0, bus.out_data}, 32'h200);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_async_data",  {21'd0, bus.out_data}, 32'd0);
    check("rs_async_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rs_async_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_group("rs_fresh", 11'h1F8, 11'h1F8, 11'h1F8, 11'h1F8, 11'h218, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
